serial_alu_seq: RTL and testbench

Bit-serial ALU sequencer for the 24-bit CPU datapath. It is the driving end of the 1-bit ALU slice interface. Per operation it feeds operand bits LSB-first into a single 1-bit slice, supplying bInvert, CIN, op and Less. It captures each result bit and the ripple carry, then returns the assembled word and flags through a valid/ready handshake. It serves area-constrained builds in place of a 24-slice ripple array.

---
 rtl/serial_alu_seq_pkg.sv | 29 ++
 rtl/serial_alu_bit.sv | 42 ++++
 rtl/serial_alu_seq.sv | 158 +++++++++++++++
 tb/tb_serial_alu_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_seq_pkg.sv
// rtl/serial_alu_seq_pkg.sv - shared constants and types for the bit-serial ALU sequencer
//
// Holds the ALU control codes seen on alu_ctl, the 1-bit slice op encodings,
// the sequencer FSM state type and the default datapath width.
package serial_alu_seq_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_CTL_W = 3;

    // ALU control codes
    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_SLT = 3'b111;

    // 1-bit slice result mux select
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_bit.sv
// rtl/serial_alu_bit.sv - 1-bit ALU slice (B-invert, full adder, 4:1 result mux)
//
// Ports:
//   a, b     operand bits
//   binvert  invert b before use (subtract / compare)
//   cin      carry into this bit
//   less     value passed through when op selects OP_LESS
//   op       result select: AND, OR, ADD, LESS
//   res      selected result bit
//   cout     full-adder carry out
module serial_alu_bit
    import serial_alu_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout
);

    logic bb;
    logic sum;

    assign bb   = b ^ binvert;
    assign sum  = a ^ bb ^ cin;
    assign cout = (a & bb) | (a & cin) | (bb & cin);

    always_comb begin
        res = 1'b0;
        case (op)
            OP_AND:  res = a & bb;
            OP_OR:   res = a | bb;
            OP_ADD:  res = sum;
            OP_LESS: res = less;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial ALU sequencer driving a single 1-bit slice
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake carrying alu_ctl, a, b
//   out_valid/out_ready result handshake carrying result, carry_out, overflow, zero
// One operand bit per clock is fed LSB-first into serial_alu_bit; the result
// word is valid WIDTH edges after the accept edge.
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CTL_W = DEF_CTL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CTL_W-1:0] ctl_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             is_add, is_sub, is_slt, is_and, is_or;
    logic             binv;
    logic [1:0]       op;
    logic             cin_init;
    logic             s_res, s_cout;

    logic             res_bit;
    logic [WIDTH-1:0] res_next;
    logic             ovf_msb;
    logic             slt_bit;
    logic [WIDTH-1:0] fin_result;
    logic             fin_co, fin_ov, fin_zero;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);

    always_comb begin
        is_add   = (ctl_q == CTL_W'(CTL_ADD));
        is_sub   = (ctl_q == CTL_W'(CTL_SUB));
        is_slt   = (ctl_q == CTL_W'(CTL_SLT));
        is_and   = (ctl_q == CTL_W'(CTL_AND));
        is_or    = (ctl_q == CTL_W'(CTL_OR));
        binv     = is_sub | is_slt;
        op       = OP_AND;
        if (is_or)
            op = OP_OR;
        else if (is_add | is_sub | is_slt)
            op = OP_ADD;
        cin_init = (alu_ctl == CTL_W'(CTL_SUB)) || (alu_ctl == CTL_W'(CTL_SLT));
    end

    serial_alu_bit u_bit (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .binvert (binv),
        .cin     (carry_q),
        .less    (1'b0),
        .op      (op),
        .res     (s_res),
        .cout    (s_cout)
    );

    // Result bits enter at the MSB and shift down, so after WIDTH shifts the
    // bit produced at k=0 sits in result[0].
    assign res_bit  = is_slt ? 1'b0 : s_res;
    assign res_next = {res_bit, result[WIDTH-1:1]};
    // carry_q still holds the carry into the MSB while the last bit is processed
    assign ovf_msb  = carry_q ^ s_cout;
    assign slt_bit  = s_res ^ ovf_msb;

    always_comb begin
        fin_result = '0;
        fin_co     = 1'b0;
        fin_ov     = 1'b0;
        fin_zero   = 1'b1;
        if (is_add | is_sub) begin
            fin_result = res_next;
            fin_co     = s_cout;
            fin_ov     = ovf_msb;
            fin_zero   = (res_next == '0);
        end else if (is_slt) begin
            fin_result = {{(WIDTH-1){1'b0}}, slt_bit};
            fin_co     = s_cout;
            fin_zero   = !slt_bit;
        end else if (is_and | is_or) begin
            fin_result = res_next;
            fin_zero   = (res_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            ctl_q     <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        ctl_q   <= alu_ctl;
                        carry_q <= cin_init;
                        cnt     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= s_cout;
                    if (cnt == LAST) begin
                        result    <= fin_result;
                        carry_out <= fin_co;
                        overflow  <= fin_ov;
                        zero      <= fin_zero;
                        state     <= ST_DONE;
                    end else begin
                        result <= res_next;
                        cnt    <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - directed self-checking bench for serial_alu_seq
module tb_serial_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctl;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    serial_alu_seq #(.WIDTH(24), .CTL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid; returns edges counted since the call.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] ctl, input logic [23:0] av,
                          input logic [23:0] bv, input logic [23:0] er, input logic eco,
                          input logic eov, input logic ez);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctl  = ctl;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(n);
        chk({tag, "_latency"}, 32'(n), 32'd24);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_carry"}, 32'(carry_out), 32'(eco));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctl   = 3'b000;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op("add_small", 3'b010, 24'h000005, 24'h000003, 24'h000008, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg",   3'b110, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",   3'b010, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap",  3'b010, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b1);
        run_op("slt_neg",   3'b111, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b1, 1'b0, 1'b0);
        run_op("slt_ovfc",  3'b111, 24'h7FFFFF, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1);
        run_op("and",       3'b000, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, 1'b0, 1'b0, 1'b0);
        run_op("or",        3'b001, 24'hF0F0F0, 24'h0FF0FF, 24'hFFF0FF, 1'b0, 1'b0, 1'b0);
        run_op("unsup",     3'b011, 24'h000005, 24'h000003, 24'h000000, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held in DONE while a new request waits
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctl  = 3'b010;
        a        = 24'h000001;
        b        = 24'h000001;
        @(posedge clk);
        #1;
        alu_ctl  = 3'b010;
        a        = 24'h000010;
        b        = 24'h000020;
        wait_done(n);
        chk("bp_latency", 32'(n), 32'd24);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result_hold", 32'(result), 32'h000002);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_hs_idle", 32'(in_ready), 32'd1);
        chk("bp_hs_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_done(n);
        chk("bp2_latency", 32'(n), 32'd24);
        chk("bp2_result", 32'(result), 32'h000030);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while bit 10 is in the slice
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctl  = 3'b001;
        a        = 24'h123456;
        b        = 24'h000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        chk("abort_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_idle", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);

        run_op("add_after_abort", 3'b010, 24'h00ABCD, 24'h001111, 24'h00BCDE, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
